// File: rtl/sram_bus_master.sv
// rtl/sram_bus_master.sv - synchronous initiator for the asynchronous 16-bit SRAM bus
// Optional feature macro: SRAM_BUS_MASTER_READBACK_EN (verify each write by reading it back).
module sram_bus_master #(
   parameter int ADDR_W     = 21,
   parameter int DATA_W     = 16,
   parameter int SETUP_CYC  = 1,
   parameter int ACCESS_CYC = 4,
   parameter int HOLD_CYC   = 1,
   parameter int TURN_CYC   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_rnw,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   input  logic [1:0]        cmd_be,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] sram_a,
   output logic              sram_cs,
   output logic              sram_oe,
   output logic              sram_we,
   output logic              sram_lb,
   output logic              sram_ub,
   inout  wire  [DATA_W-1:0] sram_dq
);

   localparam int CNT_W = 8;

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_HOLD, S_TURN} state_t;

   state_t             state_q, state_d, nxt;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               rb_q, rb_d;
   logic               rnw_q, rnw_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic [1:0]         be_q, be_d;
   logic               accept, load, access_end, noop;
   logic               rb_pending, final_access, rd_q, rd_d, active_d;
   logic               err_d, dq_oe, dq_oe_d;
   logic [DATA_W-1:0]  dq_out, lane_mask;

   // First phase at or after s that has a non-zero length; ACCESS is never empty.
   function automatic state_t skip_from(input state_t s);
      state_t r;
      r = s;
      if (r == S_SETUP && SETUP_CYC == 0) r = S_ACCESS;
      if (r == S_HOLD && HOLD_CYC == 0)   r = S_TURN;
      if (r == S_TURN && TURN_CYC == 0)   r = S_IDLE;
      return r;
   endfunction

   function automatic logic [CNT_W-1:0] phase_len(input state_t s);
      case (s)
         S_SETUP:  return CNT_W'(SETUP_CYC - 1);
         S_ACCESS: return CNT_W'(ACCESS_CYC - 1);
         S_HOLD:   return CNT_W'(HOLD_CYC - 1);
         S_TURN:   return CNT_W'(TURN_CYC - 1);
         default:  return '0;
      endcase
   endfunction

   assign accept    = cmd_valid & cmd_ready;
   assign rd_q      = rnw_q | rb_q;
   assign lane_mask = {{8{be_q[1]}}, {8{be_q[0]}}};

`ifdef SRAM_BUS_MASTER_READBACK_EN
   assign rb_pending   = !rnw_q && !rb_q;
   assign final_access = rnw_q | rb_q;
   assign err_d        = access_end & rb_q & (|((sram_dq ^ wdata_q) & lane_mask));
`else
   assign rb_pending   = 1'b0;
   assign final_access = 1'b1;
   assign err_d        = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rb_d       = rb_q;
      nxt        = S_IDLE;
      load       = 1'b0;
      access_end = 1'b0;
      noop       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (cmd_be == 2'b00) begin
                  noop = 1'b1;
               end else begin
                  nxt  = skip_from(S_SETUP);
                  load = 1'b1;
                  rb_d = 1'b0;
               end
            end
         end
         S_SETUP: begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            else begin nxt = S_ACCESS; load = 1'b1; end
         end
         S_ACCESS: begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            else begin access_end = 1'b1; nxt = skip_from(S_HOLD); load = 1'b1; end
         end
         S_HOLD: begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            else begin nxt = skip_from(S_TURN); load = 1'b1; end
         end
         S_TURN: begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            else begin nxt = S_IDLE; load = 1'b1; end
         end
         default: begin
            nxt  = S_IDLE;
            load = 1'b1;
         end
      endcase
      // A verified write chains straight into a read of the same word instead of idling.
      if (load && nxt == S_IDLE && rb_pending) begin
         nxt  = skip_from(S_SETUP);
         rb_d = 1'b1;
      end
      if (load) begin
         state_d = nxt;
         cnt_d   = phase_len(nxt);
      end
   end

   // Strobes are registered from the next state so each phase's outputs appear with it.
   always_comb begin
      rnw_d    = accept ? cmd_rnw   : rnw_q;
      addr_d   = accept ? cmd_addr  : addr_q;
      wdata_d  = accept ? cmd_wdata : wdata_q;
      be_d     = accept ? cmd_be    : be_q;
      rd_d     = rnw_d | rb_d;
      active_d = (state_d == S_SETUP) || (state_d == S_ACCESS) || (state_d == S_HOLD);
      dq_oe_d  = ((state_d == S_ACCESS) || (state_d == S_HOLD)) && !rd_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rb_q      <= 1'b0;
         rnw_q     <= 1'b1;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= 2'b00;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         sram_a    <= '0;
         sram_cs   <= 1'b1;
         sram_oe   <= 1'b1;
         sram_we   <= 1'b1;
         sram_lb   <= 1'b1;
         sram_ub   <= 1'b1;
         dq_oe     <= 1'b0;
         dq_out    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rb_q      <= rb_d;
         rnw_q     <= rnw_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         cmd_ready <= (state_d == S_IDLE);
         rsp_valid <= noop | (access_end & final_access);
         rsp_rdata <= (access_end && final_access && rd_q) ? (sram_dq & lane_mask) : '0;
         rsp_err   <= err_d;
         if (active_d) sram_a <= addr_d;
         sram_cs   <= !active_d;
         sram_oe   <= !((state_d == S_ACCESS) && rd_d);
         sram_we   <= !((state_d == S_ACCESS) && !rd_d);
         sram_lb   <= !(active_d && be_d[0]);
         sram_ub   <= !(active_d && be_d[1]);
         dq_oe     <= dq_oe_d;
         dq_out    <= wdata_d;
      end
   end

   assign sram_dq = dq_oe ? dq_out : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_bus_master.sv
// tb/tb_sram_bus_master.sv - directed, table-driven bench for sram_bus_master
module tb_sram_bus_master;

`ifdef SRAM_BUS_MASTER_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // default-timing instance
   logic        cmd_valid, cmd_ready, cmd_rnw;
   logic [20:0] cmd_addr;
   logic [15:0] cmd_wdata;
   logic [1:0]  cmd_be;
   logic        rsp_valid, rsp_err;
   logic [15:0] rsp_rdata;
   logic [20:0] sram_a;
   logic        sram_cs, sram_oe, sram_we, sram_lb, sram_ub;
   wire  [15:0] sram_dq;

   // minimum-timing instance (SETUP=HOLD=TURN=0, ACCESS=1)
   logic        b_cmd_valid, b_cmd_ready, b_cmd_rnw;
   logic [20:0] b_cmd_addr;
   logic [15:0] b_cmd_wdata;
   logic [1:0]  b_cmd_be;
   logic        b_rsp_valid, b_rsp_err;
   logic [15:0] b_rsp_rdata;
   logic [20:0] b_sram_a;
   logic        b_sram_cs, b_sram_oe, b_sram_we, b_sram_lb, b_sram_ub;
   wire  [15:0] b_sram_dq;

   sram_bus_master dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_rnw(cmd_rnw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .sram_a(sram_a), .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_we(sram_we),
      .sram_lb(sram_lb), .sram_ub(sram_ub), .sram_dq(sram_dq)
   );

   sram_bus_master #(.SETUP_CYC(0), .ACCESS_CYC(1), .HOLD_CYC(0), .TURN_CYC(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
      .cmd_rnw(b_cmd_rnw), .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata), .cmd_be(b_cmd_be),
      .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
      .sram_a(b_sram_a), .sram_cs(b_sram_cs), .sram_oe(b_sram_oe), .sram_we(b_sram_we),
      .sram_lb(b_sram_lb), .sram_ub(b_sram_ub), .sram_dq(b_sram_dq)
   );

   // SRAM models: stored byte lanes may be corrupted by an xor pattern on the first one
   logic [15:0] mem1 [0:255];
   logic [15:0] mem2 [0:255];
   logic [15:0] corrupt;
   logic        drive_en, pre_en;
   logic [7:0]  pre_idx;
   logic [15:0] pre_val;

   assign sram_dq   = (drive_en && !sram_cs && !sram_oe) ? mem1[sram_a[7:0]] : 16'hzzzz;
   assign b_sram_dq = (!b_sram_cs && !b_sram_oe) ? mem2[b_sram_a[7:0]] : 16'hzzzz;

   always @(posedge clk) begin
      if (pre_en) mem1[pre_idx] <= pre_val;
      else if (!sram_cs && !sram_we) begin
         if (!sram_lb) mem1[sram_a[7:0]][7:0]  <= sram_dq[7:0] ^ corrupt[7:0];
         if (!sram_ub) mem1[sram_a[7:0]][15:8] <= sram_dq[15:8] ^ corrupt[15:8];
      end
   end

   always @(posedge clk) begin
      if (!b_sram_cs && !b_sram_we) begin
         if (!b_sram_lb) mem2[b_sram_a[7:0]][7:0]  <= b_sram_dq[7:0];
         if (!b_sram_ub) mem2[b_sram_a[7:0]][15:8] <= b_sram_dq[15:8];
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rnw;
      logic [20:0] addr;
      logic [15:0] wdata;
      logic [1:0]  be;
      logic        pre;
      logic [15:0] pre_val;
      logic [15:0] corr;
      logic [15:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [11];

   task automatic run_vec(input vec_t v, input int idx);
      logic [16:0] a_cs, a_oe, a_we, a_lb, a_ub, a_rv, a_rdy;
      logic [16:0] e_cs, e_oe, e_we, e_lb, e_ub, e_rv, e_rdy;
      logic [15:0] rd_at [17];
      logic        er_at [17];
      int          addr_bad, dq_bad, rsp_c, done_c;
      bit          noop, rbw;
      noop   = (v.be == 2'b00);
      rbw    = RB && !v.rnw && !noop;
      rsp_c  = noop ? 1 : (rbw ? 13 : 6);
      done_c = noop ? 1 : (rbw ? 15 : 8);
      addr_bad = 0;
      dq_bad   = 0;
      a_cs = '0; a_oe = '0; a_we = '0; a_lb = '0; a_ub = '0; a_rv = '0; a_rdy = '0;
      e_cs = '0; e_oe = '0; e_we = '0; e_lb = '0; e_ub = '0; e_rv = '0; e_rdy = '0;
      if (v.pre) begin
         @(negedge clk);
         pre_en = 1'b1; pre_idx = v.addr[7:0]; pre_val = v.pre_val;
         @(posedge clk); #1;
         pre_en = 1'b0;
      end
      corrupt = v.corr;
      @(negedge clk);
      chk($sformatf("v%0d_ready_before", idx), 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_rnw = v.rnw; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_be = v.be;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         a_cs[c] = sram_cs; a_oe[c] = sram_oe; a_we[c] = sram_we;
         a_lb[c] = sram_lb; a_ub[c] = sram_ub; a_rv[c] = rsp_valid; a_rdy[c] = cmd_ready;
         rd_at[c] = rsp_rdata; er_at[c] = rsp_err;
         if (!sram_cs && sram_a !== v.addr) addr_bad++;
         if (!noop && !v.rnw && c >= 2 && c <= 6 && sram_dq !== v.wdata) dq_bad++;
         e_cs[c]  = !(!noop && ((c <= 6) || (rbw && c >= 8 && c <= 13)));
         e_we[c]  = !(!noop && !v.rnw && c >= 2 && c <= 5);
         e_oe[c]  = !(!noop && ((v.rnw && c >= 2 && c <= 5) || (rbw && c >= 9 && c <= 12)));
         e_lb[c]  = e_cs[c] | !v.be[0];
         e_ub[c]  = e_cs[c] | !v.be[1];
         e_rv[c]  = (c == rsp_c);
         e_rdy[c] = (c >= done_c);
      end
      chk($sformatf("v%0d_cs", idx),    32'(a_cs),  32'(e_cs));
      chk($sformatf("v%0d_we", idx),    32'(a_we),  32'(e_we));
      chk($sformatf("v%0d_oe", idx),    32'(a_oe),  32'(e_oe));
      chk($sformatf("v%0d_lb", idx),    32'(a_lb),  32'(e_lb));
      chk($sformatf("v%0d_ub", idx),    32'(a_ub),  32'(e_ub));
      chk($sformatf("v%0d_rsp_valid", idx), 32'(a_rv), 32'(e_rv));
      chk($sformatf("v%0d_cmd_ready", idx), 32'(a_rdy), 32'(e_rdy));
      chk($sformatf("v%0d_addr_bad_cycles", idx), 32'(addr_bad), 32'd0);
      chk($sformatf("v%0d_dq_bad_cycles", idx),   32'(dq_bad),   32'd0);
      chk($sformatf("v%0d_rdata", idx), 32'(rd_at[rsp_c]), 32'(v.exp_rdata));
      chk($sformatf("v%0d_err", idx),   32'(er_at[rsp_c]), 32'(v.exp_err));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int bad, both_low, rsp_n, k;
      int acc_c [3];
      logic [15:0] rsp_d [3];
      logic acc;

      //            rnw   addr       wdata     be     pre   pre_val   corr      exp_rdata                  exp_err
      vecs[0]  = '{1'b0, 21'h1ABCD, 16'hA55A, 2'b11, 1'b0, 16'h0000, 16'h0000, RB ? 16'hA55A : 16'h0000, 1'b0};
      vecs[1]  = '{1'b1, 21'h1ABCD, 16'h0000, 2'b11, 1'b0, 16'h0000, 16'h0000, 16'hA55A,                 1'b0};
      vecs[2]  = '{1'b1, 21'h00044, 16'h0000, 2'b10, 1'b1, 16'h3C7E, 16'h0000, 16'h3C00,                 1'b0};
      vecs[3]  = '{1'b1, 21'h00044, 16'h0000, 2'b01, 1'b1, 16'h3C7E, 16'h0000, 16'h007E,                 1'b0};
      vecs[4]  = '{1'b0, 21'h00055, 16'hBEEF, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000,                 1'b0};
      vecs[5]  = '{1'b0, 21'h00010, 16'h1234, 2'b11, 1'b0, 16'h0000, 16'h0100, RB ? 16'h1334 : 16'h0000, RB};
      vecs[6]  = '{1'b0, 21'h00010, 16'h1234, 2'b01, 1'b0, 16'h0000, 16'h0100, RB ? 16'h0034 : 16'h0000, 1'b0};
      vecs[7]  = '{1'b1, 21'h00010, 16'h0000, 2'b11, 1'b0, 16'h0000, 16'h0000, 16'h1334,                 1'b0};
      vecs[8]  = '{1'b1, 21'h1FFFF, 16'h0000, 2'b11, 1'b1, 16'hBEEF, 16'h0000, 16'hBEEF,                 1'b0};
      vecs[9]  = '{1'b0, 21'h00000, 16'hC3FF, 2'b10, 1'b1, 16'h5A5A, 16'h0000, RB ? 16'hC300 : 16'h0000, 1'b0};
      vecs[10] = '{1'b1, 21'h00000, 16'h0000, 2'b11, 1'b0, 16'h0000, 16'h0000, 16'hC35A,                 1'b0};

      rst_n = 1'b0;
      cmd_valid = 1'b0; cmd_rnw = 1'b1; cmd_addr = '0; cmd_wdata = '0; cmd_be = 2'b00;
      b_cmd_valid = 1'b0; b_cmd_rnw = 1'b1; b_cmd_addr = '0; b_cmd_wdata = '0; b_cmd_be = 2'b00;
      corrupt = '0; drive_en = 1'b1; pre_en = 1'b0; pre_idx = '0; pre_val = '0;

      repeat (3) @(negedge clk);
      chk("reset_ready", 32'(cmd_ready), 32'd0);
      chk("reset_strobes", 32'({sram_cs, sram_oe, sram_we, sram_lb, sram_ub}), 32'h1F);
      chk("reset_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'd0);
      chk("reset_addr", 32'(sram_a), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("release_ready_before_edge", 32'(cmd_ready), 32'd0);
      @(posedge clk); #1;
      chk("release_ready_after_edge", 32'(cmd_ready), 32'd1);

      for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

      // Read with the model silent: the master must not drive DQ while OE is low.
      drive_en = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_addr = 21'h1ABCD; cmd_wdata = 16'hFFFF; cmd_be = 2'b11;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      bad = 0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c >= 2 && c <= 5 && (sram_oe !== 1'b0 || sram_dq === 16'hFFFF)) bad++;
      end
      chk("read_dq_not_driven", 32'(bad), 32'd0);
      drive_en = 1'b1;

      // Back-to-back on the minimum-timing instance.
      both_low = 0; rsp_n = 0; k = 0;
      acc_c[0] = 0; acc_c[1] = 0; acc_c[2] = 0;
      rsp_d[0] = 16'hDEAD; rsp_d[1] = 16'hDEAD; rsp_d[2] = 16'hDEAD;
      @(negedge clk);
      b_cmd_valid = 1'b1; b_cmd_rnw = 1'b0; b_cmd_addr = 21'h00020; b_cmd_wdata = 16'h1111; b_cmd_be = 2'b11;
      for (int c = 0; c < 20; c++) begin
         if (c > 0) @(negedge clk);
         if (!b_sram_we && !b_sram_oe) both_low++;
         if (b_rsp_valid) begin
            if (rsp_n < 3) rsp_d[rsp_n] = b_rsp_rdata;
            rsp_n++;
         end
         acc = b_cmd_valid && b_cmd_ready;
         if (acc && k < 3) acc_c[k] = c;
         @(posedge clk); #1;
         if (acc) begin
            k++;
            if (k == 1) begin b_cmd_rnw = 1'b1; b_cmd_wdata = 16'h0000; end
            else if (k == 2) begin b_cmd_rnw = 1'b0; b_cmd_addr = 21'h00021; b_cmd_wdata = 16'h2222; end
            else b_cmd_valid = 1'b0;
         end
      end
      chk("b2b_accepts", 32'(k), 32'd3);
      chk("b2b_gap_01", 32'(acc_c[1] - acc_c[0]), RB ? 32'd3 : 32'd2);
      chk("b2b_gap_12", 32'(acc_c[2] - acc_c[1]), 32'd2);
      chk("b2b_responses", 32'(rsp_n), 32'd3);
      chk("b2b_we_oe_both_low", 32'(both_low), 32'd0);
      chk("b2b_rdata0", 32'(rsp_d[0]), RB ? 32'h1111 : 32'h0000);
      chk("b2b_rdata1", 32'(rsp_d[1]), 32'h1111);
      chk("b2b_rdata2", 32'(rsp_d[2]), RB ? 32'h2222 : 32'h0000);

      // Reset asserted mid-write, during ACCESS cycle 3.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_addr = 21'h00077; cmd_wdata = 16'h5A5A; cmd_be = 2'b11;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #3;
      chk("midrst_before_we", 32'(sram_we), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("midrst_strobes", 32'({sram_cs, sram_oe, sram_we, sram_lb, sram_ub}), 32'h1F);
      chk("midrst_dq_released", 32'(sram_dq === 16'h5A5A), 32'd0);
      chk("midrst_addr", 32'(sram_a), 32'd0);
      chk("midrst_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'd0);
      chk("midrst_ready", 32'(cmd_ready), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midrst_ready_before_edge", 32'(cmd_ready), 32'd0);
      @(posedge clk); #1;
      chk("midrst_ready_after_edge", 32'(cmd_ready), 32'd1);
      bad = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (rsp_valid || !sram_cs) bad++;
      end
      chk("midrst_no_response", 32'(bad), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
